// File: rtl/csr_unit.sv
// Machine-mode CSR file: single-cycle CSRRW/RS/RC returning the old value, with the
// architectural write deferred to ROB commit; holds event counters and trap state.
module csr_unit #(
  parameter int          NUM_HPM    = 4,
  parameter int          RET_W      = 2,
  parameter logic [31:0] HARTID     = 32'h0000_0000,
  parameter logic [31:0] RESET_TVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rename_csr_write,
  input  logic [2:0]         rename_op,
  input  logic [6:0]         rename_robid,
  input  logic [5:0]         rename_rd,
  input  logic [31:0]        rename_op1,
  input  logic [11:0]        rename_addr,
  output logic               csr_busy,
  output logic               csr_valid,
  output logic               csr_error,
  output logic [4:0]         csr_ecause,
  output logic [6:0]         csr_robid,
  output logic [5:0]         csr_rd,
  output logic [31:0]        csr_result,
  input  logic               rob_flush,
  input  logic [RET_W-1:0]   rob_ret_cnt,
  input  logic               rob_ret_csr,
  input  logic [6:0]         rob_csr_head,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               rob_trap_valid,
  input  logic [29:0]        rob_trap_epc,
  input  logic [4:0]         rob_trap_ecause,
  input  logic [31:0]        rob_trap_tval,
  output logic [29:0]        csr_tvec,
  output logic [29:0]        csr_epc
);

  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int INH_W = 3 + NUM_HPM;
  // mcountinhibit bit 1 (time) is hardwired to zero
  localparam logic [INH_W-1:0] INH_MASK = ~(INH_W'(32'd2));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_PEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  op_r;
  logic [6:0]  robid_r;
  logic [5:0]  rd_r;
  logic [31:0] op1_r;
  logic [11:0] addr_r;
  logic [31:0] wdata_r;

  logic [29:0]      mtvec_r;
  logic [31:0]      mscratch_r;
  logic [29:0]      mepc_r;
  logic [4:0]       mcause_r;
  logic [31:0]      mtval_r;
  logic [INH_W-1:0] inh_r;
  logic [63:0]      mcycle_r;
  logic [63:0]      minstret_r;
  logic [63:0]      hpm_r [HPM_N];

  logic        accept_s, commit_s, we_s;
  logic        suppress_s, err_s, hit_s;
  logic [31:0] rdata_s, wdata_s;
  logic        cnt_sel_s, cnt_hit_s, wr_cnt_s;
  logic [63:0] cnt_val_s;

  function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic wr,
                                           input logic hi, input logic [31:0] wd,
                                           input logic inh, input logic [63:0] inc);
    logic [63:0] nxt;
    if (wr) begin
      nxt = hi ? {wd, cur[31:0]} : {cur[63:32], wd};
    end else if (inh) begin
      nxt = cur;
    end else begin
      nxt = cur + inc;
    end
    return nxt;
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && rename_csr_write && !rob_flush;
  assign commit_s   = rob_ret_csr && (rob_csr_head == robid_r);
  assign we_s       = (state_r == ST_PEND) && commit_s && !rob_flush;
  assign suppress_s = (op_r[1:0] == 2'b00) || ((op_r[1:0] != 2'b01) && op_r[2]);
  assign err_s      = !hit_s || (!suppress_s && (addr_r[11:10] == 2'b11));
  assign cnt_sel_s  = (addr_r[11:8] == 4'hB) && (addr_r[6:5] == 2'b00);
  assign wr_cnt_s   = we_s && cnt_sel_s;

  assign csr_busy   = (state_r != ST_IDLE);
  assign csr_valid  = (state_r == ST_EXEC);
  assign csr_error  = csr_valid && err_s;
  assign csr_ecause = csr_error ? 5'd2 : 5'd0;
  assign csr_result = (csr_valid && !err_s) ? rdata_s : 32'd0;
  assign csr_robid  = robid_r;
  assign csr_rd     = rd_r;
  assign csr_tvec   = mtvec_r;
  assign csr_epc    = mepc_r;

  // Counter decode: B00/B02/B03+i with bit 7 selecting the high half
  always_comb begin
    cnt_hit_s = 1'b0;
    cnt_val_s = 64'd0;
    case (addr_r[4:0])
      5'd0: begin
        cnt_hit_s = cnt_sel_s;
        cnt_val_s = mcycle_r;
      end
      5'd2: begin
        cnt_hit_s = cnt_sel_s;
        cnt_val_s = minstret_r;
      end
      default: begin
        for (int i = 0; i < NUM_HPM; i++) begin
          cnt_hit_s = cnt_hit_s | (cnt_sel_s && (addr_r[4:0] == 5'(i + 3)));
          cnt_val_s = (addr_r[4:0] == 5'(i + 3)) ? hpm_r[i] : cnt_val_s;
        end
      end
    endcase
  end

  // Read mux and read-modify-write data for the latched op
  always_comb begin
    hit_s   = 1'b1;
    rdata_s = 32'd0;
    case (addr_r)
      12'h305: rdata_s = {mtvec_r, 2'b00};
      12'h340: rdata_s = mscratch_r;
      12'h341: rdata_s = {mepc_r, 2'b00};
      12'h342: rdata_s = {27'd0, mcause_r};
      12'h343: rdata_s = mtval_r;
      12'h320: rdata_s = 32'(inh_r);
      12'hF11, 12'hF12, 12'hF13: rdata_s = 32'd0;
      12'hF14: rdata_s = HARTID;
      default: begin
        hit_s   = cnt_hit_s;
        rdata_s = addr_r[7] ? cnt_val_s[63:32] : cnt_val_s[31:0];
      end
    endcase
    case (op_r[1:0])
      2'b01:   wdata_s = op1_r;
      2'b10:   wdata_s = rdata_s | op1_r;
      2'b11:   wdata_s = rdata_s & ~op1_r;
      default: wdata_s = rdata_s;
    endcase
  end

  // Next-state logic; a flush returns to idle from any state
  always_comb begin
    state_s = state_r;
    if (rob_flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = rename_csr_write ? ST_EXEC : ST_IDLE;
        ST_EXEC: state_s = (err_s || suppress_s) ? ST_WAIT : ST_PEND;
        ST_PEND: state_s = commit_s ? ST_IDLE : ST_PEND;
        ST_WAIT: state_s = commit_s ? ST_IDLE : ST_WAIT;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the accepted op, and its write data during EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 3'd0;
      robid_r <= 7'd0;
      rd_r    <= 6'd0;
      op1_r   <= 32'd0;
      addr_r  <= 12'd0;
      wdata_r <= 32'd0;
    end else begin
      if (accept_s) begin
        op_r    <= rename_op;
        robid_r <= rename_robid;
        rd_r    <= rename_rd;
        op1_r   <= rename_op1;
        addr_r  <= rename_addr;
      end
      if (state_r == ST_EXEC) begin
        wdata_r <= wdata_s;
      end
    end
  end

  // Plain CSRs; a trap overrides a same-cycle commit write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_r    <= RESET_TVEC[31:2];
      mscratch_r <= 32'd0;
      mepc_r     <= 30'd0;
      mcause_r   <= 5'd0;
      mtval_r    <= 32'd0;
      inh_r      <= '0;
    end else begin
      if (we_s) begin
        case (addr_r)
          12'h305: mtvec_r    <= wdata_r[31:2];
          12'h340: mscratch_r <= wdata_r;
          12'h341: mepc_r     <= wdata_r[31:2];
          12'h342: mcause_r   <= wdata_r[4:0];
          12'h343: mtval_r    <= wdata_r;
          12'h320: inh_r      <= wdata_r[INH_W-1:0] & INH_MASK;
          default: mtval_r    <= mtval_r;
        endcase
      end
      if (rob_trap_valid) begin
        mepc_r   <= rob_trap_epc;
        mcause_r <= rob_trap_ecause;
        mtval_r  <= rob_trap_tval;
      end
    end
  end

  // 64-bit counters: a committed half-write freezes that counter for the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
      for (int i = 0; i < HPM_N; i++) begin
        hpm_r[i] <= 64'd0;
      end
    end else begin
      mcycle_r   <= cnt_next(mcycle_r, wr_cnt_s && (addr_r[4:0] == 5'd0), addr_r[7],
                             wdata_r, inh_r[0], 64'd1);
      minstret_r <= cnt_next(minstret_r, wr_cnt_s && (addr_r[4:0] == 5'd2), addr_r[7],
                             wdata_r, inh_r[2], 64'(rob_ret_cnt));
      for (int i = 0; i < NUM_HPM; i++) begin
        hpm_r[i] <= cnt_next(hpm_r[i], wr_cnt_s && (addr_r[4:0] == 5'(i + 3)), addr_r[7],
                             wdata_r, inh_r[3 + i], 64'(hpm_event[i]));
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: table-driven decode vectors, directed multi-cycle
// sequences and randomized ops compared against an op-level reference model.
module tb_csr_unit;

  localparam int          NUM_HPM = 4;
  localparam int          RET_W   = 2;
  localparam logic [31:0] HARTID  = 32'h0000_00A5;
  localparam logic [31:0] M_INH_MASK = 32'((64'd1 << (3 + NUM_HPM)) - 64'd1) & ~32'd2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rename_csr_write;
  logic [2:0]         rename_op;
  logic [6:0]         rename_robid;
  logic [5:0]         rename_rd;
  logic [31:0]        rename_op1;
  logic [11:0]        rename_addr;
  logic               csr_busy, csr_valid, csr_error;
  logic [4:0]         csr_ecause;
  logic [6:0]         csr_robid;
  logic [5:0]         csr_rd;
  logic [31:0]        csr_result;
  logic               rob_flush;
  logic [RET_W-1:0]   rob_ret_cnt;
  logic               rob_ret_csr;
  logic [6:0]         rob_csr_head;
  logic [NUM_HPM-1:0] hpm_event;
  logic               rob_trap_valid;
  logic [29:0]        rob_trap_epc;
  logic [4:0]         rob_trap_ecause;
  logic [31:0]        rob_trap_tval;
  logic [29:0]        csr_tvec, csr_epc;

  csr_unit #(.NUM_HPM(NUM_HPM), .RET_W(RET_W), .HARTID(HARTID),
             .RESET_TVEC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .rename_csr_write(rename_csr_write), .rename_op(rename_op),
    .rename_robid(rename_robid), .rename_rd(rename_rd),
    .rename_op1(rename_op1), .rename_addr(rename_addr),
    .csr_busy(csr_busy), .csr_valid(csr_valid), .csr_error(csr_error),
    .csr_ecause(csr_ecause), .csr_robid(csr_robid), .csr_rd(csr_rd),
    .csr_result(csr_result), .rob_flush(rob_flush), .rob_ret_cnt(rob_ret_cnt),
    .rob_ret_csr(rob_ret_csr), .rob_csr_head(rob_csr_head), .hpm_event(hpm_event),
    .rob_trap_valid(rob_trap_valid), .rob_trap_epc(rob_trap_epc),
    .rob_trap_ecause(rob_trap_ecause), .rob_trap_tval(rob_trap_tval),
    .csr_tvec(csr_tvec), .csr_epc(csr_epc)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
  logic [63:0] m_cnt [NUM_HPM + 3];
  logic        m_wr_en;
  logic [11:0] m_wr_addr;
  logic [31:0] m_wr_data;

  int checks = 0;
  int errors = 0;
  bit bg_rand = 1'b0;
  logic [6:0] robid_ctr = 7'd0;

  function automatic bit is_cnt(input logic [11:0] a);
    return (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
  endfunction

  function automatic int cidx(input logic [11:0] a);
    return int'(a) % 32;
  endfunction

  function automatic logic [63:0] cnt_inc(input int c);
    if (c == 0) return 64'd1;
    if (c == 2) return 64'(rob_ret_cnt);
    if (c >= 3) return 64'(hpm_event[c - 3]);
    return 64'd0;
  endfunction

  function automatic void mread(input logic [11:0] a, output bit ok, output logic [31:0] v);
    int c;
    ok = 1'b1;
    v  = 32'd0;
    c  = cidx(a);
    case (a)
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h320: v = m_inh;
      12'hF11, 12'hF12, 12'hF13: v = 32'd0;
      12'hF14: v = HARTID;
      default: begin
        if (is_cnt(a) && (c == 0 || c == 2 || (c >= 3 && c < 3 + NUM_HPM)))
          v = (a >= 12'hB80) ? m_cnt[c][63:32] : m_cnt[c][31:0];
        else
          ok = 1'b0;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtvec <= 32'h0000_0100;
      m_mscratch <= 32'd0; m_mepc <= 32'd0; m_mcause <= 32'd0;
      m_mtval <= 32'd0; m_inh <= 32'd0;
      for (int c = 0; c < NUM_HPM + 3; c++) m_cnt[c] <= 64'd0;
    end else begin
      for (int c = 0; c < NUM_HPM + 3; c++) begin
        if (m_wr_en && is_cnt(m_wr_addr) && cidx(m_wr_addr) == c) begin
          if (m_wr_addr >= 12'hB80) m_cnt[c] <= {m_wr_data, m_cnt[c][31:0]};
          else                      m_cnt[c] <= {m_cnt[c][63:32], m_wr_data};
        end else if (!m_inh[c]) begin
          m_cnt[c] <= m_cnt[c] + cnt_inc(c);
        end
      end
      if (m_wr_en) begin
        case (m_wr_addr)
          12'h305: m_mtvec    <= m_wr_data & ~32'd3;
          12'h340: m_mscratch <= m_wr_data;
          12'h341: m_mepc     <= m_wr_data & ~32'd3;
          12'h342: m_mcause   <= m_wr_data & 32'h1F;
          12'h343: m_mtval    <= m_wr_data;
          12'h320: m_inh      <= m_wr_data & M_INH_MASK;
          default: ;
        endcase
      end
      if (rob_trap_valid) begin
        m_mepc   <= {rob_trap_epc, 2'b00};
        m_mcause <= {27'd0, rob_trap_ecause};
        m_mtval  <= rob_trap_tval;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bg();
    if (bg_rand) begin
      hpm_event   = NUM_HPM'($urandom);
      rob_ret_cnt = RET_W'($urandom);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    bg();
  endtask

  // Issue one op (called just after a rising edge), check EXEC outputs against the
  // model, then commit or flush after 'delay' idle cycles.
  task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] op1,
                       input int delay, input bit flush,
                       output logic [31:0] res, output logic err_seen);
    bit ok, sup, err;
    logic [31:0] old, wd;
    chk("busy_before", csr_busy, 1'b0);
    rename_csr_write = 1'b1;
    rename_op = op; rename_addr = addr; rename_op1 = op1;
    rename_robid = robid_ctr; rename_rd = 6'($urandom);
    cycle();
    rename_csr_write = 1'b0;
    @(negedge clk);
    mread(addr, ok, old);
    sup = (op[1:0] == 2'b00) || (op[1:0] != 2'b01 && op[2]);
    err = !ok || (!sup && addr[11:10] == 2'b11);
    chk("valid", csr_valid, 1'b1);
    chk("error", csr_error, err);
    chk("ecause", csr_ecause, err ? 5'd2 : 5'd0);
    chk("result", csr_result, err ? 32'd0 : old);
    chk("robid", csr_robid, rename_robid);
    chk("rd", csr_rd, rename_rd);
    res = csr_result;
    err_seen = csr_error;
    wd = (op[1:0] == 2'b01) ? op1 : (op[1:0] == 2'b10) ? (old | op1) : (old & ~op1);
    cycle();
    chk("valid_pulse", csr_valid, 1'b0);
    chk("busy_pending", csr_busy, 1'b1);
    repeat (delay) cycle();
    if (flush) begin
      rob_flush = 1'b1;
    end else begin
      rob_ret_csr = 1'b1; rob_csr_head = rename_robid;
      m_wr_en = !sup && !err; m_wr_addr = addr; m_wr_data = wd;
    end
    cycle();
    rob_flush = 1'b0; rob_ret_csr = 1'b0; m_wr_en = 1'b0;
    chk("busy_after", csr_busy, 1'b0);
    robid_ctr++;
  endtask

  task automatic trap(input logic [29:0] epc, input logic [4:0] cause, input logic [31:0] tval);
    rob_trap_valid = 1'b1; rob_trap_epc = epc; rob_trap_ecause = cause; rob_trap_tval = tval;
    cycle();
    rob_trap_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] op1;
    logic        err;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [31:0] r;
    logic e;
    logic [11:0] alist [17];

    tbl[0]  = '{3'b110, 12'hF14, 32'd0,          1'b0, HARTID};
    tbl[1]  = '{3'b000, 12'hF14, 32'd0,          1'b0, HARTID};
    tbl[2]  = '{3'b001, 12'hF14, 32'd1,          1'b1, 32'd0};
    tbl[3]  = '{3'b110, 12'h7C0, 32'd0,          1'b1, 32'd0};
    tbl[4]  = '{3'b110, 12'hF11, 32'd0,          1'b0, 32'd0};
    tbl[5]  = '{3'b011, 12'hF12, 32'd1,          1'b1, 32'd0};
    tbl[6]  = '{3'b110, 12'h305, 32'd0,          1'b0, 32'h100};
    tbl[7]  = '{3'b001, 12'h305, 32'h2003,       1'b0, 32'h100};
    tbl[8]  = '{3'b110, 12'h305, 32'd0,          1'b0, 32'h2000};
    tbl[9]  = '{3'b001, 12'h342, 32'hFFFF_FFFF,  1'b0, 32'd0};
    tbl[10] = '{3'b110, 12'h342, 32'd0,          1'b0, 32'h1F};
    tbl[11] = '{3'b110, 12'hB01, 32'd0,          1'b1, 32'd0};
    tbl[12] = '{3'b110, 12'hB07, 32'd0,          1'b1, 32'd0};
    tbl[13] = '{3'b010, 12'h340, 32'd0,          1'b0, 32'd0};
    tbl[14] = '{3'b110, 12'hB86, 32'd0,          1'b0, 32'd0};
    tbl[15] = '{3'b001, 12'h320, 32'hFFFF_FFFF,  1'b0, 32'd0};
    tbl[16] = '{3'b110, 12'h320, 32'd0,          1'b0, 32'h7D};
    tbl[17] = '{3'b001, 12'h320, 32'd0,          1'b0, 32'h7D};
    alist = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h320, 12'hB00, 12'hB80,
              12'hB02, 12'hB82, 12'hB03, 12'hB86, 12'hB07, 12'hF14, 12'hF11, 12'h7C0, 12'hB01};

    rst_n = 1'b0;
    rename_csr_write = 1'b0; rename_op = 3'd0; rename_robid = 7'd0; rename_rd = 6'd0;
    rename_op1 = 32'd0; rename_addr = 12'd0; rob_flush = 1'b0; rob_ret_cnt = '0;
    rob_ret_csr = 1'b0; rob_csr_head = 7'd0; hpm_event = '0; rob_trap_valid = 1'b0;
    rob_trap_epc = 30'd0; rob_trap_ecause = 5'd0; rob_trap_tval = 32'd0;
    m_wr_en = 1'b0; m_wr_addr = 12'd0; m_wr_data = 32'd0;

    #22;
    chk("rst_busy", csr_busy, 1'b0);
    chk("rst_valid", csr_valid, 1'b0);
    chk("rst_error", csr_error, 1'b0);
    chk("rst_result", csr_result, 32'd0);
    chk("rst_tvec", csr_tvec, 30'h40);
    chk("rst_epc", csr_epc, 30'd0);
    rst_n = 1'b1;

    // mcycle read: 3 idle edges plus the accept edge
    repeat (3) cycle();
    do_op(3'b110, 12'hB00, 32'd0, 5, 1'b0, r, e);
    chk("mcycle_since_reset", r, 32'd4);

    for (int k = 0; k < 18; k++) begin
      do_op(tbl[k].op, tbl[k].addr, tbl[k].op1, int'($urandom_range(0, 2)), 1'b0, r, e);
      chk($sformatf("tbl%0d_res", k), r, tbl[k].res);
      chk($sformatf("tbl%0d_err", k), e, tbl[k].err);
    end
    chk("tvec_written", csr_tvec, 30'h800);

    // Flushed write is dropped, committed write lands
    do_op(3'b001, 12'h340, 32'hDEAD_BEEF, 1, 1'b1, r, e);
    do_op(3'b110, 12'h340, 32'd0, 0, 1'b0, r, e);
    chk("mscratch_after_flush", r, 32'd0);
    do_op(3'b001, 12'h340, 32'hDEAD_BEEF, 0, 1'b0, r, e);
    do_op(3'b110, 12'h340, 32'd0, 0, 1'b0, r, e);
    chk("mscratch_committed", r, 32'hDEAD_BEEF);

    // Carry out of the low half of mcycle
    do_op(3'b001, 12'hB80, 32'd0, 0, 1'b0, r, e);
    do_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 0, 1'b0, r, e);
    repeat (3) cycle();
    do_op(3'b110, 12'hB80, 32'd0, 0, 1'b0, r, e);
    chk("mcycle_carry", r, 32'd1);

    // minstret inhibit at 3 retirements per cycle
    rob_ret_cnt = 2'd3;
    do_op(3'b001, 12'h320, 32'd4, 0, 1'b0, r, e);
    do_op(3'b110, 12'hB02, 32'd0, 0, 1'b0, r, e);
    repeat (10) cycle();
    do_op(3'b110, 12'hB02, 32'd0, 0, 1'b0, r, e);
    do_op(3'b001, 12'h320, 32'd0, 0, 1'b0, r, e);
    repeat (10) cycle();
    do_op(3'b110, 12'hB02, 32'd0, 0, 1'b0, r, e);
    rob_ret_cnt = 2'd0;

    // Trap load
    trap(30'h10, 5'd5, 32'h1234);
    chk("trap_epc_out", csr_epc, 30'h10);
    do_op(3'b110, 12'h341, 32'd0, 0, 1'b0, r, e);
    chk("trap_mepc", r, 32'h40);
    do_op(3'b110, 12'h342, 32'd0, 0, 1'b0, r, e);
    chk("trap_mcause", r, 32'd5);
    do_op(3'b110, 12'h343, 32'd0, 0, 1'b0, r, e);
    chk("trap_mtval", r, 32'h1234);

    // Randomized ops with background counter events, flushes and traps
    bg_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0)
        trap(30'($urandom), 5'($urandom), $urandom);
      do_op(3'($urandom), alist[$urandom_range(0, 16)], $urandom,
            int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), r, e);
    end
    bg_rand = 1'b0;
    chk("rand_tvec", csr_tvec, m_mtvec[31:2]);
    chk("rand_epc", csr_epc, m_mepc[31:2]);

    // Reset in the middle of an op loses it
    rename_csr_write = 1'b1; rename_op = 3'b001; rename_addr = 12'h340;
    rename_op1 = 32'h1; rename_robid = robid_ctr;
    cycle();
    rename_csr_write = 1'b0;
    chk("midop_busy", csr_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", csr_busy, 1'b0);
    chk("midop_rst_valid", csr_valid, 1'b0);
    chk("midop_rst_tvec", csr_tvec, 30'h40);
    #2;
    rst_n = 1'b1;
    cycle();
    chk("midop_idle", csr_busy, 1'b0);
    do_op(3'b110, 12'h340, 32'd0, 0, 1'b0, r, e);
    chk("midop_mscratch", r, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
